// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths and write-back entry type
package regfile_pkg;

    localparam int REG_ID_W = 4;
    localparam int DATA_W   = 16;

    typedef struct packed {
        logic [REG_ID_W-1:0] reg_id;
        logic [DATA_W-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_match.sv
// rtl/wbq_match.sv - youngest-match search over queued write-back entries
module wbq_match
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t           i_entries [DEPTH],
    input  logic [DEPTH-1:0]    i_valid,
    input  logic [PTR_W-1:0]    i_head,
    input  logic [REG_ID_W-1:0] i_src_reg,
    output logic                o_hit,
    output logic [DATA_W-1:0]   o_data
);

    logic [PTR_W-1:0] w_slot;

    // Walk slots oldest-to-youngest from the head; a later match overwrites, so the youngest wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_slot = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_slot = i_head + PTR_W'(k);
            if (i_valid[w_slot] && (i_entries[w_slot].reg_id == i_src_reg)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_slot].data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order register write-back FIFO, optional forwarding under REGFILE_WBQ_BYPASS_EN
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [REG_ID_W-1:0]     in_reg,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    drain_en,
    output logic                    wr_en,
    output logic [REG_ID_W-1:0]     wr_reg,
    output logic [DATA_W-1:0]       wr_data,
    input  logic [REG_ID_W-1:0]     src_reg,
    output logic                    fwd_hit,
    output logic [DATA_W-1:0]       fwd_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_push;
    logic             w_pop;

    // A full queue refuses pushes even when the head drains this cycle.
    assign in_ready = (r_count < CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign wr_en    = !empty && drain_en;
    assign wr_reg   = wr_en ? r_mem[r_rd_ptr].reg_id : '0;
    assign wr_data  = wr_en ? r_mem[r_rd_ptr].data   : '0;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = wr_en;

    // Entry storage; contents outside the valid window are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{reg_id: in_reg, data: in_data};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef REGFILE_WBQ_BYPASS_EN
    logic [DEPTH-1:0] w_valid;

    // A slot is live when its distance from the head is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_valid
        logic [PTR_W-1:0] w_off;
        assign w_off      = PTR_W'(g) - r_rd_ptr;
        assign w_valid[g] = ({1'b0, w_off} < r_count);
    end

    wbq_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .i_entries (r_mem),
        .i_valid   (w_valid),
        .i_head    (r_rd_ptr),
        .i_src_reg (src_reg),
        .o_hit     (fwd_hit),
        .o_data    (fwd_data)
    );
`else
    logic w_unused_src;

    assign w_unused_src = ^src_reg;
    assign fwd_hit      = 1'b0;
    assign fwd_data     = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - scoreboard bench for regfile_wb_queue
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_reg;
    logic [15:0] in_data;
    logic        drain_en;
    logic        wr_en;
    logic [3:0]  wr_reg;
    logic [15:0] wr_data;
    logic [3:0]  src_reg;
    logic        fwd_hit;
    logic [15:0] fwd_data;
    logic [2:0]  count;
    logic        empty;

    int n_checks = 0;
    int n_errors = 0;

    logic [19:0] sb [$];

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_reg   (in_reg),
        .in_data  (in_data),
        .drain_en (drain_en),
        .wr_en    (wr_en),
        .wr_reg   (wr_reg),
        .wr_data  (wr_data),
        .src_reg  (src_reg),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .count    (count),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic        exp_wr;
        logic        exp_hit;
        logic [15:0] exp_fwd;
        exp_wr = drain_en && (sb.size() > 0);
        chk("wr_en", wr_en, exp_wr);
        if (exp_wr) begin
            chk("wr_reg", wr_reg, sb[0][19:16]);
            chk("wr_data", wr_data, sb[0][15:0]);
        end else begin
            chk("wr_reg_idle", wr_reg, 0);
            chk("wr_data_idle", wr_data, 0);
        end
        chk("count", count, sb.size());
        chk("empty", empty, sb.size() == 0);
        chk("in_ready", in_ready, sb.size() < DEPTH);
        exp_hit = 1'b0;
        exp_fwd = '0;
`ifdef REGFILE_WBQ_BYPASS_EN
        foreach (sb[i]) begin
            if (sb[i][19:16] == src_reg) begin
                exp_hit = 1'b1;
                exp_fwd = sb[i][15:0];
            end
        end
`endif
        chk("fwd_hit", fwd_hit, exp_hit);
        chk("fwd_data", fwd_data, exp_fwd);
    endtask

    // One cycle: check at the falling edge, then apply the reference queue update at the rising edge.
    task automatic step();
        logic do_pop;
        logic do_push;
        @(negedge clk);
        check_outputs();
        do_pop  = drain_en && (sb.size() > 0);
        do_push = in_valid && (sb.size() < DEPTH);
        @(posedge clk);
        if (do_pop) void'(sb.pop_front());
        if (do_push) sb.push_back({in_reg, in_data});
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic [15:0] d);
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_reg"}, wr_reg, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_fwd_hit"}, fwd_hit, 0);
        chk({tag, "_fwd_data"}, fwd_data, 0);
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_reg   = '0;
        in_data  = '0;
        drain_en = 1'b1;
        src_reg  = '0;
        #3;
        reset_checks("por");
        #4;
        rst = 1'b1;

        // Single push appears on the write port the following cycle.
        drain_en = 1'b1;
        drive(4'd3, 16'h1234);
        idle(2);

        // Fill, reject the fifth push, then drain in order.
        drain_en = 1'b0;
        drive(4'd1, 16'h000A);
        drive(4'd2, 16'h000B);
        drive(4'd3, 16'h000C);
        drive(4'd4, 16'h000D);
        drive(4'd5, 16'h000E);
        idle(1);
        drain_en = 1'b1;
        idle(5);

        // Full queue with push and drain together pops only.
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) drive(4'(i + 6), 16'(16'h0100 + i));
        drain_en = 1'b1;
        drive(4'hF, 16'hDEAD);
        drain_en = 1'b0;
        idle(1);
        drain_en = 1'b1;
        idle(4);

        // Duplicate destinations: forwarding returns the youngest, including while the head pops.
        drain_en = 1'b0;
        src_reg  = 4'd5;
        drive(4'd5, 16'h1111);
        drive(4'd5, 16'h2222);
        idle(1);
        src_reg = 4'd6;
        idle(1);
        src_reg  = 4'd5;
        drain_en = 1'b1;
        idle(3);

        // Asynchronous reset mid-operation discards pending entries.
        drain_en = 1'b0;
        drive(4'd7, 16'h7777);
        drive(4'd8, 16'h8888);
        drive(4'd9, 16'h9999);
        in_valid = 1'b0;
        drain_en = 1'b1;
        src_reg  = 4'd8;
        #2;
        rst = 1'b0;
        #1;
        reset_checks("midrst");
        sb.delete();
        #1;
        rst = 1'b1;
        idle(3);

        // Sustained push and drain across pointer wrap keeps occupancy at one.
        drain_en = 1'b1;
        src_reg  = 4'd2;
        for (int i = 0; i < 11; i++) drive(4'(i), 16'(16'h0A00 + i));
        idle(2);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_reg   = 4'($urandom_range(0, 7));
            in_data  = 16'($urandom);
            drain_en = ($urandom_range(0, 2) != 0);
            src_reg  = 4'($urandom_range(0, 7));
            step();
        end
        drain_en = 1'b1;
        idle(DEPTH + 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
